// File: rtl/ram_port_master_if.sv
// Command/response/RAM-port bundle for ram_port_master.
// master modport: the ram_port_master side. slave modport: the client pipeline plus the RAM.
interface ram_port_master_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 10
) ();

  // Command channel
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;

  // RAM port
  logic              ram_ce;
  logic              ram_r_w;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_datain;
  logic [DWIDTH-1:0] ram_dataout;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dataout,
    output req_ready, rsp_valid, rsp_rdata, ram_ce, ram_r_w, ram_addr, ram_datain
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dataout,
    input  req_ready, rsp_valid, rsp_rdata, ram_ce, ram_r_w, ram_addr, ram_datain
  );

endinterface

// File: rtl/ram_port_master.sv
// ram_port_master: valid/ready front end for one port of a single-clock,
// read-first block RAM. Commands are passed straight to the RAM port, the
// registered read word is captured one cycle later into a small response
// FIFO, and credits (FIFO entries + in-flight capture) gate command acceptance.
//
// Optional feature macro: RAM_PORT_MASTER_WRITE_ACK_EN
//   defined   - every accepted write returns one response (the pre-write word)
//   undefined - writes return nothing, need no credit and never stall
module ram_port_master #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned AWIDTH    = 10,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_port_master_if.master      bus,
  output logic                   idle
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [DWIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              inflight_q;

  logic [CW-1:0]     occupancy_c;
  logic              credit_ok_c;
  logic              req_ready_c;
  logic              req_fire_c;
  logic              rsp_gen_c;
  logic              push_c;
  logic              pop_c;

  // Credit check, acceptance and response-generation decode
  always_comb begin
    occupancy_c = count_q + CW'(inflight_q);
    credit_ok_c = (occupancy_c < CW'(RSP_DEPTH));
`ifdef RAM_PORT_MASTER_WRITE_ACK_EN
    req_ready_c = credit_ok_c;
`else
    // A write with no response consumes no FIFO slot, so it never waits
    req_ready_c = bus.req_we | credit_ok_c;
`endif
    req_fire_c  = bus.req_valid & req_ready_c;
`ifdef RAM_PORT_MASTER_WRITE_ACK_EN
    rsp_gen_c   = req_fire_c;
`else
    rsp_gen_c   = req_fire_c & ~bus.req_we;
`endif
    push_c      = inflight_q;
    pop_c       = (count_q != '0) & bus.rsp_ready;
  end

  // RAM port is a direct mapping of the accepted command
  assign bus.req_ready  = req_ready_c;
  assign bus.ram_ce     = req_fire_c;
  assign bus.ram_r_w    = bus.req_we;
  assign bus.ram_addr   = bus.req_addr;
  assign bus.ram_datain = bus.req_wdata;

  // Response side: head of FIFO, valid whenever not empty
  assign bus.rsp_valid  = (count_q != '0);
  assign bus.rsp_rdata  = mem_q[rd_ptr_q];
  assign idle           = ~inflight_q & (count_q == '0);

  // Marks the cycle in which the RAM presents data for a response-producing command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rsp_gen_c;
    end
  end

  // FIFO storage: capture ram_dataout at the write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= bus.ram_dataout;
    end
  end

  // FIFO pointers (natural wrap) and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
